// File: rtl/inst_encoder_loader_pkg.sv
// Shared constants for the instruction encoder/loader and the decode side:
// symbolic op IDs, MIPS opcode/funct/REGIMM codes, FSM states and
// word-assembly helpers.
package inst_encoder_loader_pkg;

  // Symbolic op IDs carried on the command link
  typedef enum logic [5:0] {
    ENC_SLL   = 6'd0,  ENC_SRL   = 6'd1,  ENC_SRA   = 6'd2,  ENC_SLLV  = 6'd3,
    ENC_SRLV  = 6'd4,  ENC_SRAV  = 6'd5,  ENC_JR    = 6'd6,  ENC_JALR  = 6'd7,
    ENC_MOVZ  = 6'd8,  ENC_MOVN  = 6'd9,  ENC_ADD   = 6'd10, ENC_ADDU  = 6'd11,
    ENC_SUB   = 6'd12, ENC_SUBU  = 6'd13, ENC_AND   = 6'd14, ENC_OR    = 6'd15,
    ENC_XOR   = 6'd16, ENC_NOR   = 6'd17, ENC_SLT   = 6'd18, ENC_SLTU  = 6'd19,
    ENC_BLTZ  = 6'd20, ENC_BGEZ  = 6'd21, ENC_BLTZAL= 6'd22, ENC_BGEZAL= 6'd23,
    ENC_J     = 6'd24, ENC_JAL   = 6'd25, ENC_BEQ   = 6'd26, ENC_BNE   = 6'd27,
    ENC_BLEZ  = 6'd28, ENC_BGTZ  = 6'd29, ENC_ADDI  = 6'd30, ENC_ADDIU = 6'd31,
    ENC_SLTI  = 6'd32, ENC_SLTIU = 6'd33, ENC_ANDI  = 6'd34, ENC_ORI   = 6'd35,
    ENC_XORI  = 6'd36, ENC_LUI   = 6'd37, ENC_LW    = 6'd38, ENC_SW    = 6'd39
  } enc_op_e;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02,
                         OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE  = 6'h05,
                         OP_BLEZ    = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI = 6'h08,
                         OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU= 6'h0B,
                         OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI = 6'h0E,
                         OP_LUI     = 6'h0F, OP_LW     = 6'h23, OP_SW   = 6'h2B;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03,
                         FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07,
                         FN_JR   = 6'h08, FN_JALR = 6'h09, FN_MOVZ = 6'h0A,
                         FN_MOVN = 6'h0B, FN_ADD  = 6'h20, FN_ADDU = 6'h21,
                         FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24,
                         FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27,
                         FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  // REGIMM rt-field codes
  localparam logic [4:0] RI_BLTZ = 5'b00000, RI_BGEZ = 5'b00001,
                         RI_BLTZAL = 5'b10000, RI_BGEZAL = 5'b10001;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_WRITE = 2'd2
  } ld_state_e;

  // R-format word assembly
  function automatic logic [31:0] r_fmt(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sa,
                                        input logic [5:0] fn);
    return {OP_SPECIAL, rs, rt, rd, sa, fn};
  endfunction

  // I-format word assembly (REGIMM reuses it with the code in the rt slot)
  function automatic logic [31:0] i_fmt(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/inst_encoder_loader_if.sv
// Command link and IMEM write port of the program loader.
interface inst_encoder_loader_if #(parameter int ADDR_W = 10);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [5:0]        cmd_op;
  logic [4:0]        cmd_rs;
  logic [4:0]        cmd_rt;
  logic [4:0]        cmd_rd;
  logic [4:0]        cmd_sa;
  logic [15:0]       cmd_imm;
  logic [25:0]       cmd_target;
  logic              cmd_setaddr;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              im_ready;

  // Command source / IMEM side
  modport master (
    output cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_sa, cmd_imm,
           cmd_target, cmd_setaddr, im_ready,
    input  cmd_ready, im_we, im_addr, im_wdata
  );

  // Loader side
  modport slave (
    input  cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_sa, cmd_imm,
           cmd_target, cmd_setaddr, im_ready,
    output cmd_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/inst_encoder_loader_enc.sv
// Combinational encoder: symbolic op plus fields -> 32-bit MIPS word.
// Fields a format does not use are dropped or forced to zero.
module inst_word_encoder
  import inst_encoder_loader_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  sa,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  // Select the format and forced-zero fields for each op
  always_comb begin
    word  = 32'h0000_0000;
    legal = 1'b1;
    case (op)
      ENC_SLL:    word = r_fmt(5'd0, rt, rd, sa, FN_SLL);
      ENC_SRL:    word = r_fmt(5'd0, rt, rd, sa, FN_SRL);
      ENC_SRA:    word = r_fmt(5'd0, rt, rd, sa, FN_SRA);
      ENC_SLLV:   word = r_fmt(rs, rt, rd, 5'd0, FN_SLLV);
      ENC_SRLV:   word = r_fmt(rs, rt, rd, 5'd0, FN_SRLV);
      ENC_SRAV:   word = r_fmt(rs, rt, rd, 5'd0, FN_SRAV);
      ENC_JR:     word = r_fmt(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      ENC_JALR:   word = r_fmt(rs, 5'd0, rd, 5'd0, FN_JALR);
      ENC_MOVZ:   word = r_fmt(rs, rt, rd, 5'd0, FN_MOVZ);
      ENC_MOVN:   word = r_fmt(rs, rt, rd, 5'd0, FN_MOVN);
      ENC_ADD:    word = r_fmt(rs, rt, rd, 5'd0, FN_ADD);
      ENC_ADDU:   word = r_fmt(rs, rt, rd, 5'd0, FN_ADDU);
      ENC_SUB:    word = r_fmt(rs, rt, rd, 5'd0, FN_SUB);
      ENC_SUBU:   word = r_fmt(rs, rt, rd, 5'd0, FN_SUBU);
      ENC_AND:    word = r_fmt(rs, rt, rd, 5'd0, FN_AND);
      ENC_OR:     word = r_fmt(rs, rt, rd, 5'd0, FN_OR);
      ENC_XOR:    word = r_fmt(rs, rt, rd, 5'd0, FN_XOR);
      ENC_NOR:    word = r_fmt(rs, rt, rd, 5'd0, FN_NOR);
      ENC_SLT:    word = r_fmt(rs, rt, rd, 5'd0, FN_SLT);
      ENC_SLTU:   word = r_fmt(rs, rt, rd, 5'd0, FN_SLTU);
      ENC_BLTZ:   word = i_fmt(OP_REGIMM, rs, RI_BLTZ, imm);
      ENC_BGEZ:   word = i_fmt(OP_REGIMM, rs, RI_BGEZ, imm);
      ENC_BLTZAL: word = i_fmt(OP_REGIMM, rs, RI_BLTZAL, imm);
      ENC_BGEZAL: word = i_fmt(OP_REGIMM, rs, RI_BGEZAL, imm);
      ENC_J:      word = {OP_J, target};
      ENC_JAL:    word = {OP_JAL, target};
      ENC_BEQ:    word = i_fmt(OP_BEQ, rs, rt, imm);
      ENC_BNE:    word = i_fmt(OP_BNE, rs, rt, imm);
      ENC_BLEZ:   word = i_fmt(OP_BLEZ, rs, 5'd0, imm);
      ENC_BGTZ:   word = i_fmt(OP_BGTZ, rs, 5'd0, imm);
      ENC_ADDI:   word = i_fmt(OP_ADDI, rs, rt, imm);
      ENC_ADDIU:  word = i_fmt(OP_ADDIU, rs, rt, imm);
      ENC_SLTI:   word = i_fmt(OP_SLTI, rs, rt, imm);
      ENC_SLTIU:  word = i_fmt(OP_SLTIU, rs, rt, imm);
      ENC_ANDI:   word = i_fmt(OP_ANDI, rs, rt, imm);
      ENC_ORI:    word = i_fmt(OP_ORI, rs, rt, imm);
      ENC_XORI:   word = i_fmt(OP_XORI, rs, rt, imm);
      ENC_LUI:    word = i_fmt(OP_LUI, 5'd0, rt, imm);
      ENC_LW:     word = i_fmt(OP_LW, rs, rt, imm);
      ENC_SW:     word = i_fmt(OP_SW, rs, rt, imm);
      default: begin
        word  = 32'h0000_0000;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder_loader.sv
// Program loader: accepts symbolic commands, encodes them and writes one
// word per accepted command into IMEM at an auto-incrementing address.
module inst_encoder_loader
  import inst_encoder_loader_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int BASE_DEF = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inst_encoder_loader_if.slave bus,
  output logic                 err,
  output logic [ADDR_W:0]      inst_count
);

  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  ld_state_e         state_r, state_s;
  logic              cmd_ready_r, cmd_ready_s;
  logic              im_we_r, im_we_s;
  logic [ADDR_W-1:0] im_addr_r, im_addr_s;
  logic [31:0]       im_wdata_r, im_wdata_s;
  logic              err_r, err_s;
  logic [ADDR_W:0]   count_r, count_s;
  logic [31:0]       enc_word_s;
  logic              enc_legal_s;

  inst_word_encoder u_enc (
    .op     (bus.cmd_op),
    .rs     (bus.cmd_rs),
    .rt     (bus.cmd_rt),
    .rd     (bus.cmd_rd),
    .sa     (bus.cmd_sa),
    .imm    (bus.cmd_imm),
    .target (bus.cmd_target),
    .word   (enc_word_s),
    .legal  (enc_legal_s)
  );

  // State and all outputs are registered; reset drops im_we at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b0;
      im_we_r     <= 1'b0;
      im_addr_r   <= ADDR_W'(BASE_DEF);
      im_wdata_r  <= 32'h0000_0000;
      err_r       <= 1'b0;
      count_r     <= '0;
    end else begin
      state_r     <= state_s;
      cmd_ready_r <= cmd_ready_s;
      im_we_r     <= im_we_s;
      im_addr_r   <= im_addr_s;
      im_wdata_r  <= im_wdata_s;
      err_r       <= err_s;
      count_r     <= count_s;
    end
  end

  // Next-state and next-output logic; cmd_ready is high exactly in READY
  always_comb begin
    state_s     = state_r;
    cmd_ready_s = 1'b0;
    im_we_s     = im_we_r;
    im_addr_s   = im_addr_r;
    im_wdata_s  = im_wdata_r;
    err_s       = err_r;
    count_s     = count_r;
    case (state_r)
      ST_IDLE: begin
        state_s     = ST_READY;
        cmd_ready_s = 1'b1;
      end
      ST_READY: begin
        cmd_ready_s = 1'b1;
        if (bus.cmd_valid && cmd_ready_r) begin
          if (bus.cmd_setaddr) begin
            im_addr_s = bus.cmd_imm[ADDR_W-1:0];
          end else if (enc_legal_s) begin
            im_wdata_s  = enc_word_s;
            im_we_s     = 1'b1;
            state_s     = ST_WRITE;
            cmd_ready_s = 1'b0;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = ST_READY;
        end
      end
      ST_WRITE: begin
        if (im_we_r && bus.im_ready) begin
          im_we_s     = 1'b0;
          im_addr_s   = im_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_s     = ST_READY;
          cmd_ready_s = 1'b1;
          if (count_r != CNT_MAX) begin
            count_s = count_r + {{ADDR_W{1'b0}}, 1'b1};
          end else begin
            count_s = count_r;
          end
        end else begin
          im_we_s = im_we_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        im_we_s = 1'b0;
      end
    endcase
  end

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.im_we     = im_we_r;
  assign bus.im_addr   = im_addr_r;
  assign bus.im_wdata  = im_wdata_r;
  assign err           = err_r;
  assign inst_count    = count_r;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed self-checking bench for inst_encoder_loader.
module tb_inst_encoder_loader;
  import inst_encoder_loader_pkg::*;

  localparam int ADDR_W = 10;

  logic            clk;
  logic            rst_n;
  logic            err;
  logic [ADDR_W:0] inst_count;
  int              checks;
  int              errors;

  inst_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

  inst_encoder_loader #(.ADDR_W(ADDR_W), .BASE_DEF(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .err        (err),
    .inst_count (inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for cmd_ready (bounded), presents one command for one accepting edge
  task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic setaddr);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (!bus.cmd_ready) check("ready_timeout", 32'd0, 32'd1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_rs      = rs;
    bus.cmd_rt      = rt;
    bus.cmd_rd      = rd;
    bus.cmd_sa      = sa;
    bus.cmd_imm     = imm;
    bus.cmd_target  = tgt;
    bus.cmd_setaddr = setaddr;
    step();
    bus.cmd_valid   = 1'b0;
    bus.cmd_setaddr = 1'b0;
  endtask

  // Checks the pending write right after accept, then lets it complete (im_ready=1)
  task automatic expect_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
    check({tag, "_we"}, 32'(bus.im_we), 32'd1);
    check({tag, "_addr"}, 32'(bus.im_addr), addr);
    check({tag, "_data"}, bus.im_wdata, data);
    step();
    check({tag, "_we_drop"}, 32'(bus.im_we), 32'd0);
    check({tag, "_addr_inc"}, 32'(bus.im_addr), (addr + 32'd1) & 32'h3FF);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 6'd0; bus.cmd_rs = 5'd0; bus.cmd_rt = 5'd0;
    bus.cmd_rd = 5'd0; bus.cmd_sa = 5'd0; bus.cmd_imm = 16'd0; bus.cmd_target = 26'd0;
    bus.cmd_setaddr = 1'b0; bus.im_ready = 1'b1;
    repeat (3) step();
    check("rst_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_we", 32'(bus.im_we), 32'd0);
    check("rst_addr", 32'(bus.im_addr), 32'd0);
    check("rst_wdata", bus.im_wdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_count", 32'(inst_count), 32'd0);
    rst_n = 1'b1;
    check("idle_ready", 32'(bus.cmd_ready), 32'd0);
    step();
    check("ready_up", 32'(bus.cmd_ready), 32'd1);

    // addu rd=3 rs=1 rt=2
    send(ENC_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
    check("addu_ready_low", 32'(bus.cmd_ready), 32'd0);
    expect_write("addu", 32'd0, 32'h0022_1821);
    check("cnt1", 32'(inst_count), 32'd1);
    // sll with rs forced to zero, then lw
    send(ENC_SLL, 5'd7, 5'd3, 5'd2, 5'd4, 16'd0, 26'd0, 1'b0);
    expect_write("sll", 32'd1, 32'h0003_1100);
    send(ENC_LW, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'd0, 1'b0);
    expect_write("lw", 32'd2, 32'h8FA8_0004);
    // setaddr to the top word, wrap
    send(ENC_SLL, 5'd0, 5'd0, 5'd0, 5'd0, 16'h03FF, 26'd0, 1'b1);
    check("setaddr_addr", 32'(bus.im_addr), 32'h3FF);
    check("setaddr_nowe", 32'(bus.im_we), 32'd0);
    check("setaddr_cnt", 32'(inst_count), 32'd3);
    send(ENC_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10, 1'b0);
    expect_write("j", 32'h3FF, 32'h0800_0010);
    send(ENC_BGEZAL, 5'd4, 5'd0, 5'd0, 5'd0, 16'hFFFF, 26'd0, 1'b0);
    expect_write("bgezal", 32'd0, 32'h0491_FFFF);
    check("cnt5", 32'(inst_count), 32'd5);

    // stalled write: or rd=5 rs=6 rt=7
    bus.im_ready = 1'b0;
    send(ENC_OR, 5'd6, 5'd7, 5'd5, 5'd9, 16'd0, 26'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("stall_we", 32'(bus.im_we), 32'd1);
      check("stall_addr", 32'(bus.im_addr), 32'd1);
      check("stall_data", bus.im_wdata, 32'h00C7_2825);
      check("stall_ready", 32'(bus.cmd_ready), 32'd0);
      check("stall_cnt", 32'(inst_count), 32'd5);
      step();
    end
    bus.im_ready = 1'b1;
    step();
    check("stall_done_we", 32'(bus.im_we), 32'd0);
    check("stall_done_addr", 32'(bus.im_addr), 32'd2);
    check("stall_done_cnt", 32'(inst_count), 32'd6);

    // illegal op
    send(6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
    check("ill_err", 32'(err), 32'd1);
    check("ill_we", 32'(bus.im_we), 32'd0);
    check("ill_addr", 32'(bus.im_addr), 32'd2);
    check("ill_cnt", 32'(inst_count), 32'd6);
    step();
    check("ill_err_sticky", 32'(err), 32'd1);
    check("ill_we2", 32'(bus.im_we), 32'd0);
    send(ENC_ADDIU, 5'd0, 5'd9, 5'd0, 5'd0, 16'h0001, 26'd0, 1'b0);
    expect_write("addiu", 32'd2, 32'h2409_0001);
    send(ENC_JR, 5'd31, 5'd5, 5'd6, 5'd7, 16'd0, 26'd0, 1'b0);
    expect_write("jr", 32'd3, 32'h03E0_0008);
    send(ENC_BLEZ, 5'd3, 5'd5, 5'd0, 5'd0, 16'h0010, 26'd0, 1'b0);
    expect_write("blez", 32'd4, 32'h1860_0010);
    send(ENC_LUI, 5'd5, 5'd1, 5'd0, 5'd0, 16'h1234, 26'd0, 1'b0);
    expect_write("lui", 32'd5, 32'h3C01_1234);
    check("cnt10", 32'(inst_count), 32'd10);
    check("err_still", 32'(err), 32'd1);

    // reset during a stalled write
    bus.im_ready = 1'b0;
    send(ENC_SW, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0008, 26'd0, 1'b0);
    check("sw_we", 32'(bus.im_we), 32'd1);
    check("sw_data", bus.im_wdata, 32'hAFBF_0008);
    #2 rst_n = 1'b0;
    #1;
    check("arst_we", 32'(bus.im_we), 32'd0);
    step();
    step();
    #2 rst_n = 1'b1;
    bus.im_ready = 1'b1;
    #1;
    check("post_addr", 32'(bus.im_addr), 32'd0);
    check("post_cnt", 32'(inst_count), 32'd0);
    check("post_err", 32'(err), 32'd0);
    check("post_we", 32'(bus.im_we), 32'd0);
    step();
    check("post_ready", 32'(bus.cmd_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
